// File: rtl/simd_iterator_engine.sv
// Address-iterator engine: per-namespace base/stride tables, operand arbitration,
// loop post-increment and delayed write-address generation. AddrWidth must equal 2*ImmWidth.
module simd_iterator_engine #(
    parameter int unsigned NumNs     = 8,
    parameter int unsigned IndexBits = 5,
    parameter int unsigned ImmWidth  = 16,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned WrDelay   = 2,
    localparam int unsigned NsIdBits = (NumNs > 1) ? $clog2(NumNs) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cfg_valid_i,
    input  logic                       cfg_stride_i,
    input  logic [1:0]                 cfg_mode_i,
    input  logic [NsIdBits-1:0]        cfg_ns_i,
    input  logic [IndexBits-1:0]       cfg_idx_i,
    input  logic [ImmWidth-1:0]        cfg_imm_i,
    input  logic                       src1_valid_i,
    input  logic [NsIdBits-1:0]        src1_ns_i,
    input  logic [IndexBits-1:0]       src1_idx_i,
    input  logic                       src2_valid_i,
    input  logic [NsIdBits-1:0]        src2_ns_i,
    input  logic [IndexBits-1:0]       src2_idx_i,
    input  logic                       dest_valid_i,
    input  logic [NsIdBits-1:0]        dest_ns_i,
    input  logic [IndexBits-1:0]       dest_idx_i,
    input  logic                       in_loop_i,
    output logic [NumNs*AddrWidth-1:0] rd_addr_o,
    output logic [NumNs-1:0]           rd_rq_o,
    output logic [NumNs*AddrWidth-1:0] wr_addr_o,
    output logic [NumNs-1:0]           wr_rq_o,
    output logic                       conflict_o,
    output logic                       inc_drop_o
);

    localparam int unsigned Depth = 1 << IndexBits;

    logic [AddrWidth-1:0] base_q   [NumNs][Depth];
    logic [AddrWidth-1:0] stride_q [NumNs][Depth];
    logic [ImmWidth-1:0]  low_q;

    logic [NumNs-1:0]     hit1, hit2, hitd;
    logic [NumNs-1:0]     is_rd, is_wr, inc, drop, ns_conflict;
    logic [NumNs-1:0]     cfg_base_hit, cfg_stride_hit;
    logic [IndexBits-1:0] sel_idx  [NumNs];
    logic [AddrWidth-1:0] cur_base [NumNs];
    logic [AddrWidth-1:0] cur_sum  [NumNs];
    logic [AddrWidth-1:0] cfg_val;

    logic [NumNs-1:0]     rd_rq_q;
    logic [AddrWidth-1:0] rd_addr_q [NumNs];
    logic                 conflict_q;
    logic [NumNs-1:0]     wr_rq_q   [WrDelay+1];
    logic [AddrWidth-1:0] wr_addr_q [WrDelay+1][NumNs];

    // Modes 01/10 splice the previously latched immediate in as the upper half.
    always_comb begin
        cfg_val = '0;
        unique case (cfg_mode_i)
            2'b00:   cfg_val = {{ImmWidth{1'b0}}, cfg_imm_i};
            2'b11:   cfg_val = {{ImmWidth{cfg_imm_i[ImmWidth-1]}}, cfg_imm_i};
            default: cfg_val = {low_q, cfg_imm_i};
        endcase
    end

    always_comb begin
        hit1           = '0;
        hit2           = '0;
        hitd           = '0;
        is_rd          = '0;
        is_wr          = '0;
        inc            = '0;
        drop           = '0;
        ns_conflict    = '0;
        cfg_base_hit   = '0;
        cfg_stride_hit = '0;
        sel_idx        = '{default: '0};
        cur_base       = '{default: '0};
        cur_sum        = '{default: '0};
        for (int n = 0; n < int'(NumNs); n++) begin
            hit1[n]  = src1_valid_i && (src1_ns_i == NsIdBits'(n));
            hit2[n]  = src2_valid_i && (src2_ns_i == NsIdBits'(n));
            hitd[n]  = dest_valid_i && (dest_ns_i == NsIdBits'(n));
            is_rd[n] = hit1[n] | hit2[n];
            is_wr[n] = hitd[n] & ~is_rd[n];
            sel_idx[n] = hit1[n] ? src1_idx_i : (hit2[n] ? src2_idx_i : dest_idx_i);
            cur_base[n] = base_q[n][sel_idx[n]];
            cur_sum[n]  = cur_base[n] + stride_q[n][sel_idx[n]];
            inc[n]      = (is_rd[n] | is_wr[n]) & in_loop_i;
            cfg_base_hit[n]   = cfg_valid_i & ~cfg_stride_i & (cfg_ns_i == NsIdBits'(n));
            cfg_stride_hit[n] = cfg_valid_i & cfg_stride_i & (cfg_ns_i == NsIdBits'(n));
            // The base table has one write port per namespace; config takes it.
            drop[n] = inc[n] & cfg_base_hit[n];
            ns_conflict[n] = (hit1[n] & hit2[n]) | (hit1[n] & hitd[n]) | (hit2[n] & hitd[n]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            low_q      <= '0;
            rd_rq_q    <= '0;
            conflict_q <= 1'b0;
            for (int n = 0; n < int'(NumNs); n++) begin
                rd_addr_q[n] <= '0;
                for (int i = 0; i < int'(Depth); i++) begin
                    base_q[n][i]   <= '0;
                    stride_q[n][i] <= '0;
                end
            end
            for (int s = 0; s <= int'(WrDelay); s++) begin
                wr_rq_q[s] <= '0;
                for (int n = 0; n < int'(NumNs); n++) begin
                    wr_addr_q[s][n] <= '0;
                end
            end
        end else begin
            if (cfg_valid_i) begin
                low_q <= cfg_imm_i;
            end
            rd_rq_q    <= is_rd;
            conflict_q <= |ns_conflict;
            wr_rq_q[0] <= is_wr;
            for (int s = 1; s <= int'(WrDelay); s++) begin
                wr_rq_q[s] <= wr_rq_q[s-1];
            end
            for (int n = 0; n < int'(NumNs); n++) begin
                if (cfg_base_hit[n]) begin
                    base_q[n][cfg_idx_i] <= cfg_val;
                end else if (inc[n]) begin
                    base_q[n][sel_idx[n]] <= cur_sum[n];
                end
                if (cfg_stride_hit[n]) begin
                    stride_q[n][cfg_idx_i] <= cfg_val;
                end
                if (is_rd[n]) begin
                    rd_addr_q[n] <= cur_base[n];
                end
                if (is_wr[n]) begin
                    wr_addr_q[0][n] <= cur_base[n];
                end
                // Each stage only loads on a live request so idle lanes hold their address.
                for (int s = 1; s <= int'(WrDelay); s++) begin
                    if (wr_rq_q[s-1][n]) begin
                        wr_addr_q[s][n] <= wr_addr_q[s-1][n];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_addr_o = '0;
        wr_addr_o = '0;
        for (int n = 0; n < int'(NumNs); n++) begin
            rd_addr_o[n*AddrWidth +: AddrWidth] = rd_addr_q[n];
            wr_addr_o[n*AddrWidth +: AddrWidth] = wr_addr_q[WrDelay][n];
        end
    end

    assign rd_rq_o    = rd_rq_q;
    assign wr_rq_o    = wr_rq_q[WrDelay];
    assign conflict_o = conflict_q;
    assign inc_drop_o = (|drop) & ~reset_i;

endmodule
